// File: rtl/i2c_slave_regbank.sv
// Register bank behind an I2C slave byte controller: pointer loaded by the first
// written byte, auto-increment with wrap/saturate, prefetched reads, write-protected top.
module i2c_slave_regbank #(
    parameter int DW       = 8,
    parameter int AW       = 7,
    parameter int AUTO_INC = 1,
    parameter int WRAP     = 1,
    parameter int RO_BASE  = 1 << AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
    input  logic          rd,
    input  logic          rx_valid,
    input  logic [DW-1:0] rx_data,
    input  logic          tx_req,
    output logic [DW-1:0] tx_data,
    output logic          tx_valid,
    output logic [AW-1:0] ptr,
    output logic          wr_err,
    input  logic          err_clr
);

    localparam int DEPTH = 1 << AW;
    // One extra bit so the default RO_BASE (= depth) means "nothing protected".
    localparam logic [AW:0] RO_LIM = (AW+1)'(RO_BASE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        WR   = 2'd2,
        RD   = 2'd3
    } state_t;

    state_t        state_r, state_nxt_s;
    logic [AW-1:0] ptr_r, ptr_nxt_s;
    logic [DW-1:0] tx_data_r, tx_data_nxt_s;
    logic          tx_valid_r, tx_valid_nxt_s;
    logic          wr_err_r, wr_err_nxt_s;
    logic          mem_we_s;
    logic          err_set_s;
    logic          writable_s;
    logic [DW-1:0] mem_r [DEPTH];

    function automatic logic [AW-1:0] advance(input logic [AW-1:0] p);
        if (AUTO_INC == 0) begin
            return p;
        end else if (p == {AW{1'b1}}) begin
            return (WRAP != 0) ? {AW{1'b0}} : p;
        end else begin
            return p + AW'(1'b1);
        end
    endfunction

    assign writable_s = ({1'b0, ptr_r} < RO_LIM);

    // Next-state and datapath decode; start outranks stop, both outrank the state actions.
    always_comb begin
        state_nxt_s    = state_r;
        ptr_nxt_s      = ptr_r;
        tx_data_nxt_s  = tx_data_r;
        tx_valid_nxt_s = tx_valid_r;
        mem_we_s       = 1'b0;
        err_set_s      = 1'b0;

        if (start) begin
            state_nxt_s    = rd ? RD : ADDR;
            tx_valid_nxt_s = 1'b0;
        end else if (stop) begin
            state_nxt_s    = IDLE;
            tx_valid_nxt_s = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_nxt_s = IDLE;
                end
                ADDR: begin
                    if (rx_valid) begin
                        ptr_nxt_s   = rx_data[AW-1:0];
                        state_nxt_s = WR;
                    end else begin
                        state_nxt_s = ADDR;
                    end
                end
                WR: begin
                    if (rx_valid) begin
                        mem_we_s  = writable_s;
                        err_set_s = ~writable_s;
                        ptr_nxt_s = advance(ptr_r);
                    end else begin
                        ptr_nxt_s = ptr_r;
                    end
                end
                RD: begin
                    if (!tx_valid_r) begin
                        tx_data_nxt_s  = mem_r[ptr_r];
                        tx_valid_nxt_s = 1'b1;
                    end else if (tx_req) begin
                        ptr_nxt_s      = advance(ptr_r);
                        tx_valid_nxt_s = 1'b0;
                    end else begin
                        tx_valid_nxt_s = 1'b1;
                    end
                end
                default: begin
                    state_nxt_s    = IDLE;
                    tx_valid_nxt_s = 1'b0;
                end
            endcase
        end

        if (err_set_s) begin
            wr_err_nxt_s = 1'b1;
        end else if (err_clr) begin
            wr_err_nxt_s = 1'b0;
        end else begin
            wr_err_nxt_s = wr_err_r;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            ptr_r      <= {AW{1'b0}};
            tx_data_r  <= {DW{1'b0}};
            tx_valid_r <= 1'b0;
            wr_err_r   <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            ptr_r      <= ptr_nxt_s;
            tx_data_r  <= tx_data_nxt_s;
            tx_valid_r <= tx_valid_nxt_s;
            wr_err_r   <= wr_err_nxt_s;
        end
    end

    // Storage array; deliberately not reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[ptr_r] <= rx_data;
        end
    end

    assign tx_data  = tx_data_r;
    assign tx_valid = tx_valid_r;
    assign ptr      = ptr_r;
    assign wr_err   = wr_err_r;

endmodule

// File: tb/tb_i2c_slave_regbank.sv
// Scoreboard bench: four parameter variants share one stimulus stream and are each
// compared against a transaction-level memory/pointer model.
module tb_i2c_slave_regbank;

    localparam int N = 4;
    localparam int AINC  [N] = '{1, 1, 1, 0};
    localparam int WRAPP [N] = '{1, 0, 1, 1};
    localparam int ROB   [N] = '{128, 128, 64, 128};

    typedef struct {
        logic [7:0] val;
        bit         care;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, stop = 1'b0, rd = 1'b0, rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       tx_req = 1'b0, err_clr = 1'b0;
    logic [7:0] tx_data_w  [N];
    logic       tx_valid_w [N];
    logic [6:0] ptr_w      [N];
    logic       wr_err_w   [N];

    int total = 0;
    int bad = 0;

    logic [7:0] mem_m   [N][128];
    bit         known_m [N][128];
    int         ptr_m   [N];
    bit         err_m   [N];
    exp_t       exp_q   [N][$];
    logic [7:0] wd [$];
    bit         prev_v  [N];
    exp_t       mon_e;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        i2c_slave_regbank #(
            .DW(8), .AW(7), .AUTO_INC(AINC[g]), .WRAP(WRAPP[g]), .RO_BASE(ROB[g])
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .rd(rd),
            .rx_valid(rx_valid), .rx_data(rx_data), .tx_req(tx_req),
            .tx_data(tx_data_w[g]), .tx_valid(tx_valid_w[g]), .ptr(ptr_w[g]),
            .wr_err(wr_err_w[g]), .err_clr(err_clr)
        );
    end

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s dut%0d actual=%0h required=%0h", name, idx, act, req);
        end
    endtask

    function automatic int adv(input int i, input int p);
        if (AINC[i] == 0) return p;
        if (p == 127) return (WRAPP[i] != 0) ? 0 : 127;
        return p + 1;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
        start = 1'b0; stop = 1'b0; rd = 1'b0; rx_valid = 1'b0;
        rx_data = 8'h00; tx_req = 1'b0; err_clr = 1'b0;
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < N; i++) begin
            check({tag, "_ptr"}, i, ptr_w[i], ptr_m[i]);
            check({tag, "_err"}, i, wr_err_w[i], err_m[i]);
        end
    endtask

    task automatic push_exp();
        for (int i = 0; i < N; i++)
            exp_q[i].push_back('{mem_m[i][ptr_m[i]], known_m[i][ptr_m[i]]});
    endtask

    // Address byte plus the bytes queued in wd; err_clr rides on data byte clr_at.
    task automatic wr_txn(input int addr, input int clr_at);
        start = 1'b1; rd = 1'b0;
        cycle();
        rx_valid = 1'b1;
        rx_data = {1'($urandom_range(1)), 7'(addr)};
        cycle();
        for (int i = 0; i < N; i++) ptr_m[i] = addr;
        for (int k = 0; k < wd.size(); k++) begin
            rx_valid = 1'b1; rx_data = wd[k]; err_clr = (k == clr_at);
            cycle();
            for (int i = 0; i < N; i++) begin
                if (k == clr_at) err_m[i] = 1'b0;
                if (ptr_m[i] < ROB[i]) begin
                    mem_m[i][ptr_m[i]] = wd[k];
                    known_m[i][ptr_m[i]] = 1'b1;
                end else begin
                    err_m[i] = 1'b1;
                end
                ptr_m[i] = adv(i, ptr_m[i]);
            end
        end
        wd.delete();
        stop = 1'b1;
        cycle();
        check_regs("wr_txn");
    endtask

    task automatic set_ptr(input int addr);
        start = 1'b1; rd = 1'b0;
        cycle();
        rx_valid = 1'b1; rx_data = 8'(addr);
        cycle();
        for (int i = 0; i < N; i++) ptr_m[i] = addr;
    endtask

    task automatic wait_valid();
        int w = 0;
        while (!tx_valid_w[0] && w < 8) begin
            cycle();
            w++;
        end
        if (!tx_valid_w[0]) begin
            total++; bad++;
            $display("FAIL tx_valid_timeout actual=0 required=1");
        end
    endtask

    // Read n bytes; with_stop also raises stop together with the (repeated) start.
    task automatic rd_txn(input int n, input bit with_stop);
        start = 1'b1; rd = 1'b1; stop = with_stop;
        cycle();
        for (int i = 0; i < N; i++) check("rd_entry_valid", i, tx_valid_w[i], 0);
        push_exp();
        for (int k = 0; k < n; k++) begin
            wait_valid();
            tx_req = 1'b1;
            cycle();
            for (int i = 0; i < N; i++) begin
                check("txreq_drop", i, tx_valid_w[i], 0);
                ptr_m[i] = adv(i, ptr_m[i]);
            end
            push_exp();
            cycle();
        end
        stop = 1'b1;
        cycle();
        check_regs("rd_txn");
    endtask

    task automatic clr_pulse();
        err_clr = 1'b1;
        cycle();
        for (int i = 0; i < N; i++) err_m[i] = 1'b0;
        check_regs("clr");
    endtask

    // Monitor: every rising tx_valid consumes one expected byte per instance.
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (tx_valid_w[i] && !prev_v[i]) begin
                if (exp_q[i].size() == 0) begin
                    total++; bad++;
                    $display("FAIL tx_unexpected dut%0d actual=%0h required=none", i, tx_data_w[i]);
                end else begin
                    mon_e = exp_q[i].pop_front();
                    if (mon_e.care) check("tx_data", i, tx_data_w[i], mon_e.val);
                end
            end
            prev_v[i] <= tx_valid_w[i];
        end
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            ptr_m[i] = 0; err_m[i] = 1'b0; prev_v[i] = 1'b0;
            for (int a = 0; a < 128; a++) known_m[i][a] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < N; i++) check("reset_valid", i, tx_valid_w[i], 0);
        check_regs("reset");
        cycle();

        // Fill every entry with random data, then clear the resulting errors.
        for (int a = 0; a < 128; a++) wd.push_back(8'($urandom));
        wr_txn(0, -1);
        clr_pulse();

        // Basic write and read-back through a repeated start.
        wd.push_back(8'hA5); wd.push_back(8'h5A);
        wr_txn(8'h10, -1);
        set_ptr(8'h10);
        rd_txn(2, 1'b0);

        // Wrap/saturate at the top entry, then read it back.
        wd.push_back(8'h11); wd.push_back(8'h22);
        wr_txn(8'h7F, -1);
        set_ptr(8'h7F);
        rd_txn(2, 1'b0);

        // Protected region, clear, and set-beats-clear.
        wd.push_back(8'hFF);
        wr_txn(8'h40, -1);
        clr_pulse();
        wd.push_back(8'hEE);
        wr_txn(8'h40, 0);

        // start and stop together: start wins.
        set_ptr(8'h05);
        rd_txn(1, 1'b1);

        // Reset during a write after the address byte.
        start = 1'b1; rd = 1'b0;
        cycle();
        rx_valid = 1'b1; rx_data = 8'h20;
        cycle();
        rx_valid = 1'b1; rx_data = 8'h99; rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) begin
            ptr_m[i] = 0; err_m[i] = 1'b0;
            check("midrst_valid", i, tx_valid_w[i], 0);
        end
        check_regs("midrst");
        rx_valid = 1'b1; rx_data = 8'h33;
        cycle();
        check_regs("idle_rx_ignored");
        rd_txn(3, 1'b0);

        // Randomised mix of transactions.
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(3))
                0: begin
                    int nb = $urandom_range(4, 1);
                    for (int k = 0; k < nb; k++) wd.push_back(8'($urandom));
                    wr_txn($urandom_range(127), ($urandom_range(3) == 0) ? 0 : -1);
                end
                1: begin
                    set_ptr($urandom_range(127));
                    rd_txn($urandom_range(4, 1), 1'($urandom_range(1)));
                end
                2: rd_txn($urandom_range(3, 1), 1'b0);
                default: clr_pulse();
            endcase
        end

        repeat (2) cycle();
        for (int i = 0; i < N; i++) check("queue_empty", i, exp_q[i].size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_slave_regbank.md
Name: i2c_slave_regbank

Overview:
- Parametrised register bank behind the I2C slave byte-level controller; successor to the fixed 8-bit, 128-entry slave memory.
- Adds an internal register pointer loaded from the first byte of a write transaction.
- Pointer auto-increments with configurable wrap/saturate; reads are prefetched with a valid flag.
- Adds a write-protected upper region with a sticky error flag.

Parameters:
- DW, 8, data byte width in bits.
- AW, 7, pointer width; depth = 1<<AW; AW <= DW required.
- AUTO_INC, 1, 1 = pointer increments after each data byte; 0 = pointer holds.
- WRAP, 1, 1 = pointer wraps (1<<AW)-1 -> 0; 0 = pointer saturates at (1<<AW)-1.
- RO_BASE, 1<<AW, first read-only entry; entries >= RO_BASE ignore writes; default = no protected region.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse: START or repeated START with our slave address matched.
- stop  in  1  one-cycle pulse: STOP detected.
- rd  in  1  R/W bit of the current transaction, valid when start=1 (1 = master read).
- rx_valid  in  1  one-cycle pulse: rx_data holds a received byte.
- rx_data  in  DW  received byte.
- tx_req  in  1  one-cycle pulse: controller has latched tx_data and needs the next byte.
- tx_data  out  DW  byte to transmit.
- tx_valid  out  1  tx_data is valid for the current pointer.
- ptr  out  AW  current register pointer.
- wr_err  out  1  sticky: a write hit a protected entry.
- err_clr  in  1  clears wr_err.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, ptr=0, tx_data=0, tx_valid=0, wr_err=0.
  - Memory array is not reset; contents survive reset.
- States: IDLE, ADDR, WR, RD.
- start=1 from any state:
  - rd=0 -> ADDR; rd=1 -> RD.
  - ptr is kept.
  - tx_valid is cleared the same edge.
- ADDR: on rx_valid, ptr <= rx_data[AW-1:0] (upper bits ignored), then -> WR. No memory write.
- WR: on rx_valid:
  - If ptr < RO_BASE, mem[ptr] <= rx_data.
  - Otherwise no write and wr_err <= 1.
  - Pointer then advances (see rules below).
- RD:
  - When tx_valid=0, the cycle after entry or after a pointer change: tx_data <= mem[ptr], tx_valid <= 1. Latency is 1 clk.
  - On tx_req with tx_valid=1: pointer advances and tx_valid <= 0 the same edge; refetch on the next cycle.
  - tx_req while tx_valid=0 is ignored.
- Pointer advance:
  - AUTO_INC=0: ptr holds.
  - Otherwise ptr+1 modulo 1<<AW when WRAP=1.
  - When WRAP=0, ptr stays at (1<<AW)-1 once reached.
- stop=1: -> IDLE, tx_valid <= 0, ptr retained (a following read-only transaction continues from ptr).
- Simultaneous start and stop in one cycle: start wins (repeated-start semantics).
- rx_valid in IDLE or RD: ignored. tx_req outside RD: ignored.
- err_clr and wr_err set in the same cycle: set wins.
- Reads of protected entries are allowed.
- Reset asserted mid-transaction: immediate return to reset values; a partially received byte is never written.

Test Plan:
- Reset, start rd=0, rx 0x10, rx 0xA5, rx 0x5A, stop -> mem[0x10]=0xA5, mem[0x11]=0x5A, ptr=0x12, state IDLE.
- Then start rd=0, rx 0x10, start rd=1 (repeated start):
  - tx_valid rises 1 clk later with tx_data=0xA5.
  - tx_req -> tx_valid drops, next cycle tx_data=0x5A.
- Wrap: write ptr 0x7F, data 0x11, 0x22 -> mem[0x7F]=0x11, mem[0x00]=0x22, ptr=0x01.
- Saturate: same with WRAP=0 -> mem[0x7F]=0x22, ptr=0x7F.
- Protection: RO_BASE=0x40, write 0xFF to ptr 0x40 -> mem unchanged, wr_err=1 until err_clr; err_clr and a new violation in the same cycle -> wr_err stays 1.
- Reset mid-write after address byte 0x20: rst_n low for 1 clk then high -> ptr=0, tx_valid=0, state IDLE, previously written memory contents intact.
